// File: rtl/addr_map_cfg_if.sv
// Request/grant register port between software and the address-map configuration block.
interface addr_map_cfg_if #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned RegAddrWidth = 3
);
  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [RegAddrWidth-1:0] addr;
  logic [AddrWidth-1:0]    wdata;
  logic                    rvalid;
  logic [AddrWidth-1:0]    rdata;
  logic                    err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/addr_map_cfg.sv
// Shadow/active address map for addr_decode_dync: software edits a shadow copy, then commits it
// through a check/drain/swap sequence that holds the decoder in config_ongoing while the map changes.
module addr_map_cfg #(
  parameter int unsigned NoRules   = 1,
  parameter int unsigned NoIndices = 1,
  parameter int unsigned AddrWidth = 32,
  parameter type         rule_t    = logic [32+2*AddrWidth-1:0],
  parameter int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  addr_map_cfg_if.slave        bus,
  input  logic                 idle_i,
  output rule_t [NoRules-1:0]  addr_map_o,
  output logic                 en_default_idx_o,
  output logic [IdxWidth-1:0]  default_idx_o,
  output logic                 config_ongoing_o
);

  localparam int unsigned CtrlAddr = 3 * NoRules;
  localparam int unsigned StatAddr = CtrlAddr + 1;
  localparam int unsigned DefAddr  = CtrlAddr + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DRAIN,
    ST_SWAP,
    ST_SETTLE
  } state_e;

  state_e                r_state;
  logic [31:0]           r_sh_idx   [NoRules];
  logic [AddrWidth-1:0]  r_sh_start [NoRules];
  logic [AddrWidth-1:0]  r_sh_end   [NoRules];
  logic [31:0]           r_act_idx  [NoRules];
  logic [AddrWidth-1:0]  r_act_start[NoRules];
  logic [AddrWidth-1:0]  r_act_end  [NoRules];
  logic                  r_sh_def_en;
  logic [IdxWidth-1:0]   r_sh_def_idx;
  logic                  r_act_def_en;
  logic [IdxWidth-1:0]   r_act_def_idx;
  logic                  r_sticky_err;
  logic [7:0]            r_cnt;
  logic                  r_rvalid;
  logic [AddrWidth-1:0]  r_rdata;
  logic                  r_err;
  logic                  r_cfg_ongoing;

  logic                  w_gnt;
  logic [31:0]           w_addr;
  logic [AddrWidth-1:0]  w_rdata;
  logic                  w_err;
  logic                  w_shadow_ok;

  assign w_addr = 32'(bus.addr);
  assign w_gnt  = bus.req && (r_state == ST_IDLE);

  // Response data/error for the access currently presented on the port.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    if (w_addr > DefAddr) begin
      w_err = 1'b1;
    end else if (w_addr == StatAddr) begin
      if (bus.we) w_err = 1'b1;
      else        w_rdata = AddrWidth'({r_cnt, 7'd0, r_sticky_err});
    end else if (w_addr == CtrlAddr) begin
      if (bus.we && bus.wdata[0] && bus.wdata[1]) w_err = 1'b1;
    end else if (w_addr == DefAddr) begin
      if (!bus.we) w_rdata = AddrWidth'({r_sh_def_idx, r_sh_def_en});
    end else if (!bus.we) begin
      for (int unsigned r = 0; r < NoRules; r++) begin
        if (w_addr == 3*r)     w_rdata = AddrWidth'(r_sh_idx[r]);
        if (w_addr == 3*r + 1) w_rdata = r_sh_start[r];
        if (w_addr == 3*r + 2) w_rdata = r_sh_end[r];
      end
    end
  end

  // A rule with end_addr == 0 is an open-ended rule and is always range-valid.
  always_comb begin
    w_shadow_ok = (32'(r_sh_def_idx) < NoIndices);
    for (int unsigned r = 0; r < NoRules; r++) begin
      if (r_sh_idx[r] >= NoIndices) w_shadow_ok = 1'b0;
      if (!((r_sh_start[r] < r_sh_end[r]) || (r_sh_end[r] == '0))) w_shadow_ok = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_sh_def_en   <= 1'b0;
      r_sh_def_idx  <= '0;
      r_act_def_en  <= 1'b0;
      r_act_def_idx <= '0;
      r_sticky_err  <= 1'b0;
      r_cnt         <= '0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_cfg_ongoing <= 1'b0;
      for (int unsigned r = 0; r < NoRules; r++) begin
        r_sh_idx[r]    <= '0;
        r_sh_start[r]  <= '0;
        r_sh_end[r]    <= '0;
        r_act_idx[r]   <= '0;
        r_act_start[r] <= '0;
        r_act_end[r]   <= '0;
      end
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= w_gnt ? w_rdata : '0;
      r_err    <= w_gnt && w_err;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt && bus.we && !w_err) begin
            if (w_addr == CtrlAddr) begin
              if (bus.wdata[1]) begin
                r_sh_def_en  <= r_act_def_en;
                r_sh_def_idx <= r_act_def_idx;
                for (int unsigned r = 0; r < NoRules; r++) begin
                  r_sh_idx[r]   <= r_act_idx[r];
                  r_sh_start[r] <= r_act_start[r];
                  r_sh_end[r]   <= r_act_end[r];
                end
              end else if (bus.wdata[0]) begin
                r_state <= ST_CHECK;
              end
            end else if (w_addr == DefAddr) begin
              r_sh_def_en  <= bus.wdata[0];
              r_sh_def_idx <= bus.wdata[IdxWidth:1];
            end else begin
              for (int unsigned r = 0; r < NoRules; r++) begin
                if (w_addr == 3*r)     r_sh_idx[r]   <= 32'(bus.wdata);
                if (w_addr == 3*r + 1) r_sh_start[r] <= bus.wdata;
                if (w_addr == 3*r + 2) r_sh_end[r]   <= bus.wdata;
              end
            end
          end else if (w_gnt && !bus.we && (w_addr == StatAddr)) begin
            r_sticky_err <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (w_shadow_ok) begin
            r_state       <= ST_DRAIN;
            r_cfg_ongoing <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_sticky_err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (idle_i) r_state <= ST_SWAP;
        end
        ST_SWAP: begin
          r_act_def_en  <= r_sh_def_en;
          r_act_def_idx <= r_sh_def_idx;
          for (int unsigned r = 0; r < NoRules; r++) begin
            r_act_idx[r]   <= r_sh_idx[r];
            r_act_start[r] <= r_sh_start[r];
            r_act_end[r]   <= r_sh_end[r];
          end
          r_cnt   <= r_cnt + 8'd1;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_state       <= ST_IDLE;
          r_cfg_ongoing <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_cfg_ongoing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt          = w_gnt;
  assign bus.rvalid       = r_rvalid;
  assign bus.rdata        = r_rdata;
  assign bus.err          = r_err;
  assign en_default_idx_o = r_act_def_en;
  assign default_idx_o    = r_act_def_idx;
  assign config_ongoing_o = r_cfg_ongoing;

  // Active map packed in rule_t field order: idx, start_addr, end_addr.
  always_comb begin
    for (int unsigned r = 0; r < NoRules; r++) begin
      addr_map_o[r] = rule_t'({r_act_idx[r], r_act_start[r], r_act_end[r]});
    end
  end

endmodule

// File: tb/tb_addr_map_cfg.sv
// Scoreboard bench for addr_map_cfg: directed register accesses queue expected responses,
// a monitor pops them on rvalid; commit timing and map outputs are checked directly.
module tb_addr_map_cfg;
  localparam int unsigned NoRules   = 2;
  localparam int unsigned NoIndices = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned RegAw     = $clog2(3*NoRules+3);
  localparam int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1;
  localparam int unsigned RuleW     = 32 + 2*AddrWidth;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle = 1'b1;
  logic [NoRules-1:0][RuleW-1:0] addr_map;
  logic                en_def;
  logic [IdxWidth-1:0] def_idx;
  logic                cfg;

  addr_map_cfg_if #(.AddrWidth(AddrWidth), .RegAddrWidth(RegAw)) bus ();

  addr_map_cfg #(.NoRules(NoRules), .NoIndices(NoIndices), .AddrWidth(AddrWidth)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus              (bus),
    .idle_i           (idle),
    .addr_map_o       (addr_map),
    .en_default_idx_o (en_def),
    .default_idx_o    (def_idx),
    .config_ongoing_o (cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AddrWidth-1:0] rdata;
    logic                 err;
    string                tag;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int last_pulse = 0;
  int run_len = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: response scoreboard plus config_ongoing pulse-length tracker.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg) run_len++;
      else if (run_len != 0) begin
        last_pulse = run_len;
        pulse_cnt++;
        run_len = 0;
      end
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rvalid: got rdata %0h with empty queue", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          chk({e.tag, "_rdata"}, 128'(bus.rdata), 128'(e.rdata));
          chk({e.tag, "_err"}, 128'(bus.err), 128'(e.err));
        end
      end
    end
  end

  task automatic access(input logic we, input int unsigned addr, input logic [AddrWidth-1:0] wdata,
                        input logic [AddrWidth-1:0] exp_rd, input logic exp_err, input string tag,
                        output int waits);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.tag   = tag;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = RegAw'(addr);
    bus.wdata = wdata;
    exp_q.push_back(e);
    #1;
    waits = 0;
    while (!bus.gnt && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.gnt) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_timeout %s: no grant after %0d cycles, expected grant", tag, waits);
      void'(exp_q.pop_back());
      bus.req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      bus.we  = 1'b0;
    end
  endtask

  task automatic wr(input int unsigned addr, input logic [AddrWidth-1:0] d, input string tag);
    int w;
    access(1'b1, addr, d, '0, 1'b0, tag, w);
  endtask

  task automatic rd(input int unsigned addr, input logic [AddrWidth-1:0] x, input string tag);
    int w;
    access(1'b0, addr, '0, x, 1'b0, tag, w);
  endtask

  task automatic acc_err(input logic we, input int unsigned addr, input logic [AddrWidth-1:0] d,
                         input string tag);
    int w;
    access(we, addr, d, '0, 1'b1, tag, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RuleW-1:0] r0_exp;
    logic [RuleW-1:0] r1_exp;
    int saved_pulses;
    int waits;
    r0_exp = {32'd1, 32'h0000_1000, 32'h0000_2000};
    r1_exp = {32'd2, 32'h0000_8000, 32'h0000_0000};
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cfg", 128'(cfg), 0);
    chk("rst_gnt", 128'(bus.gnt), 0);
    chk("rst_rvalid", 128'(bus.rvalid), 0);
    chk("rst_err", 128'(bus.err), 0);
    chk("rst_rdata", 128'(bus.rdata), 0);
    chk("rst_map", 128'(addr_map), 0);
    chk("rst_def", 128'({en_def, def_idx}), 0);
    rst_n = 1'b1;

    // Program rule 0 and commit with idle high
    wr(0, 32'd1, "wr_r0_idx");
    wr(1, 32'h1000, "wr_r0_start");
    wr(2, 32'h2000, "wr_r0_end");
    rd(1, 32'h1000, "rd_r0_start");
    wr(6, 32'd1, "commit1");
    @(negedge clk); chk("c1_cfg_check", 128'(cfg), 0);
    @(negedge clk); chk("c1_cfg_drain", 128'(cfg), 1); chk("c1_map_drain", 128'(addr_map[0]), 0);
    @(negedge clk); chk("c1_map_swap", 128'(addr_map[0]), 0);
    @(negedge clk); chk("c1_map_new", 128'(addr_map[0]), 128'(r0_exp)); chk("c1_cfg_settle", 128'(cfg), 1);
    @(negedge clk); #2;
    chk("c1_cfg_done", 128'(cfg), 0);
    chk("c1_pulse_len", 128'(last_pulse), 3);
    rd(7, 32'h0000_0100, "status_cnt1");
    rd(7, 32'h0000_0100, "status_cnt1_again");

    // Invalid range: commit rejected, sticky error set then cleared by read
    saved_pulses = pulse_cnt;
    wr(1, 32'h3000, "wr_r0_bad_start");
    wr(6, 32'd1, "commit_bad");
    repeat (4) begin
      @(negedge clk);
      chk("bad_cfg_low", 128'(cfg), 0);
    end
    chk("bad_no_pulse", 128'(pulse_cnt), 128'(saved_pulses));
    chk("bad_map_kept", 128'(addr_map[0]), 128'(r0_exp));
    rd(7, 32'h0000_0101, "status_sticky");
    rd(7, 32'h0000_0100, "status_cleared");

    // Abort restores shadow from active
    wr(6, 32'd2, "abort");
    rd(1, 32'h1000, "rd_after_abort_start");
    rd(0, 32'd1, "rd_after_abort_idx");

    // Default rule
    wr(8, 32'd7, "wr_default");
    rd(8, 32'd7, "rd_default");
    wr(6, 32'd1, "commit_default");
    repeat (5) @(negedge clk);
    chk("def_en", 128'(en_def), 1);
    chk("def_idx", 128'(def_idx), 3);

    // Drain with idle low; a pending read must wait for IDLE
    wr(3, 32'd2, "wr_r1_idx");
    wr(4, 32'h8000, "wr_r1_start");
    wr(5, 32'h0, "wr_r1_end");
    wr(6, 32'd1, "commit_drain");
    idle = 1'b0;
    fork
      begin
        repeat (11) @(negedge clk);
        idle = 1'b1;
      end
      access(1'b0, 4, '0, 32'h8000, 1'b0, "rd_during_drain", waits);
    join
    chk("drain_grant_wait", 128'(waits), 13);
    #2;
    chk("drain_pulse_len", 128'(last_pulse), 12);
    chk("drain_map_r1", 128'(addr_map[1]), 128'(r1_exp));
    rd(7, 32'h0000_0300, "status_cnt3");

    // Reset during DRAIN
    idle = 1'b0;
    wr(6, 32'd1, "commit_reset");
    repeat (3) @(negedge clk);
    chk("rst_mid_cfg_high", 128'(cfg), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cfg", 128'(cfg), 0);
    chk("rst_mid_map", 128'(addr_map), 0);
    chk("rst_mid_def", 128'({en_def, def_idx}), 0);
    chk("rst_mid_resp", 128'({bus.rvalid, bus.err, bus.rdata}), 0);
    rst_n = 1'b1;
    idle = 1'b1;
    rd(7, 32'h0, "status_after_reset");
    rd(1, 32'h0, "shadow_after_reset");

    // Error accesses
    saved_pulses = pulse_cnt;
    acc_err(1'b0, 9, '0, "rd_oob");
    acc_err(1'b1, 9, 32'h5, "wr_oob");
    acc_err(1'b1, 7, 32'h5, "wr_status");
    acc_err(1'b1, 6, 32'h3, "ctrl_both");
    rd(6, 32'h0, "rd_ctrl");
    rd(7, 32'h0, "status_unchanged");
    chk("err_no_pulse", 128'(pulse_cnt), 128'(saved_pulses));

    // Counter wrap
    for (int i = 0; i < 255; i++) wr(6, 32'd1, "commit_wrap");
    rd(7, 32'h0000_FF00, "status_cnt255");
    wr(6, 32'd1, "commit_256");
    rd(7, 32'h0, "status_wrapped");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
